af_stack_port: RTL
==================

Name: af_stack_port

Overview:
- Moves the A/F pair between the CPU core and memory for PUSH AF and POP AF.
- Push direction: packs live flags Z/N/H/C and A into two bytes, then writes them to the stack.
- Pop direction: reads two bytes back, returns A, and returns the flag nibble on the flag-restore path that the ALU flag logic consumes.
- Generates stack addresses and the new SP value. Talks to memory through a single-beat req/ack port.

Parameters:
- ADDR_W, 16, stack pointer / memory address width
- F_LOW_MASK, 1, when 1 force F[3:0]=0 on push and ignore rdata[3:0] on pop

Ports:
- CLK  in  1  core clock, all state changes on rising edge
- nRESET  in  1  asynchronous active-low reset
- start_push  in  1  one-cycle request to begin PUSH AF
- start_pop  in  1  one-cycle request to begin POP AF
- a_in  in  8  accumulator value to push
- flag_z, flag_n, flag_h, flag_c  in  1 each  live flag register bits
- sp_in  in  ADDR_W  current SP, sampled at start
- mem_req  out  1  memory beat request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  beat address
- mem_wdata  out  8  write data
- mem_rdata  in  8  read data, valid when mem_ack=1 on a read
- mem_ack  in  1  beat completion
- a_out  out  8  popped accumulator
- a_load  out  1  one-cycle strobe: load a_out into A
- temp_flags  out  4  popped {Z,N,H,C}
- flags_load  out  1  one-cycle strobe: load temp_flags into flag register
- sp_out  out  ADDR_W  updated SP
- sp_load  out  1  one-cycle strobe: load sp_out into SP
- busy  out  1  operation in progress

Behaviour:
- Reset values (asynchronous, immediate): state IDLE, all outputs 0 (mem_req, mem_we, all strobes, busy, all data and address buses).
- States: IDLE, PUSH_HI, PUSH_LO, POP_LO, POP_HI, GAP, FINISH. GAP carries a 1-bit next-state tag.
- IDLE:
  - start_push=1 → snapshot a_in, flags and sp_in; go to PUSH_HI.
  - start_pop=1 → snapshot sp_in; go to POP_LO.
  - Both high in the same cycle → push wins; pop is dropped.
- Start requests are ignored whenever the state is not IDLE.
- busy = 1 in every state except IDLE.
- Packed F byte = {Z,N,H,C,4'b0000} when F_LOW_MASK=1. When F_LOW_MASK=0, the low nibble is also 4'b0000; it is never carried.
- PUSH_HI: mem_req=1, mem_we=1, addr=SP-1, wdata=A. On mem_ack → GAP (tag PUSH_LO).
- PUSH_LO: addr=SP-2, wdata=F. On mem_ack → FINISH with sp_out=SP-2.
- POP_LO: mem_req=1, mem_we=0, addr=SP. On mem_ack → capture temp_flags=rdata[7:4]; go to GAP (tag POP_HI).
- POP_HI: addr=SP+1. On mem_ack → capture a_out=rdata; go to FINISH with sp_out=SP+2.
- GAP: exactly one cycle with mem_req=0, then the tagged state.
- Every beat holds mem_req, mem_addr and mem_wdata stable until the cycle in which mem_ack=1 is sampled. mem_req falls the following cycle.
- mem_ack while mem_req=0 is ignored.
- FINISH (one cycle), then IDLE:
  - sp_load=1 on both push and pop.
  - On pop only: flags_load=1 and a_load=1, all in the same cycle.
  - Push never asserts a_load or flags_load.
- Latency with zero-wait memory (ack in the first req cycle):
  - start at cycle 0; req high cycles 1 and 3; FINISH cycle 4; idle cycle 5.
  - A new start is accepted in cycle 5.
- Address arithmetic is modulo 2^ADDR_W:
  - push from SP=0x0000 → addresses 0xFFFF, 0xFFFE; sp_out=0xFFFE.
  - pop from SP=0xFFFF → addresses 0xFFFF, 0x0000; sp_out=0x0001.
- Snapshot rule: changes to a_in, flags or sp_in after start do not affect the operation in flight.
- nRESET mid-operation: mem_req drops asynchronously. No strobe fires and SP is not updated. The next operation requires a fresh start.

Decomposition:
- Shared package:
  - state enum encoding;
  - F-byte bit positions (FZ=7, FN=6, FH=5, FC=4);
  - F_LOW constant 4'b0000.
- One sub-module: af_pack (combinational). Packs flags into the F byte and unpacks rdata into {Z,N,H,C}; reused by push and pop.
- FSM, SP arithmetic and handshake stay in af_stack_port.

Test Plan:
- Push, zero-wait: A=0x3C, Z=1 N=0 H=1 C=0, SP=0xDFF0.
  - → writes 0x3C@0xDFEF, then 0xA0@0xDFEE.
  - → sp_load with 0xDFEE in cycle 4; no a_load or flags_load.
- Pop, wait states: mem rdata 0x5F@0xC000 and 0x77@0xC001, ack after 3 req cycles each, SP=0xC000.
  - → temp_flags=4'b0101, a_out=0x77, sp_out=0xC002.
  - → a_load, flags_load and sp_load in the same single cycle; low nibble 0xF discarded.
- Wrap: push from SP=0x0000 → addresses 0xFFFF/0xFFFE, sp_out 0xFFFE. Pop from SP=0xFFFF → 0xFFFF/0x0000, sp_out 0x0001.
- Collisions: start_push and start_pop in the same cycle → push sequence only.
  - start_pop during a push → ignored; busy stays 1 until FINISH.
- Snapshot: change a_in 0x11→0x22 and C 0→1 the cycle after start_push → memory still receives 0x11 and an F byte with C=0.
- Reset: assert nRESET low while PUSH_LO waits for ack → mem_req=0 immediately, no sp_load.
  - After release → IDLE, busy=0, next start_pop runs normally.

Source files
------------

// File: rtl/af_stack_port_pkg.sv
// Shared types and constants for the A/F stack transfer port.
package af_stack_port_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPushHi,
    StPushLo,
    StPopLo,
    StPopHi,
    StGap,
    StFinish
  } state_e;

  // Where GAP goes once its single idle cycle is over.
  typedef enum logic {
    GapToPushLo,
    GapToPopHi
  } gap_tag_e;

  localparam int unsigned FZ = 7;
  localparam int unsigned FN = 6;
  localparam int unsigned FH = 5;
  localparam int unsigned FC = 4;

  localparam logic [3:0] F_LOW = 4'b0000;

endpackage

// File: rtl/af_pack.sv
// Packs live Z/N/H/C into the F byte and unpacks a popped F byte back to {Z,N,H,C}.
module af_pack #(
  parameter int unsigned F_LOW_MASK = 1
) (
  input  logic       z,
  input  logic       n,
  input  logic       h,
  input  logic       c,
  input  logic [7:0] rdata,
  output logic [7:0] f_byte,
  output logic [3:0] flags
);
  import af_stack_port_pkg::*;

  always_comb begin
    f_byte      = '0;
    f_byte[FZ]  = z;
    f_byte[FN]  = n;
    f_byte[FH]  = h;
    f_byte[FC]  = c;
    f_byte[3:0] = F_LOW;
  end

  assign flags = {rdata[FZ], rdata[FN], rdata[FH], rdata[FC]};

  // The low nibble never carries state in either mask setting, so it is dropped on pop.
  logic unused_low;
  assign unused_low = ^{rdata[3:0], F_LOW_MASK != 0};

endmodule

// File: rtl/af_stack_port.sv
// PUSH AF / POP AF sequencer: two single-beat stack accesses, then one-cycle load strobes.
module af_stack_port #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned F_LOW_MASK = 1
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              start_push,
  input  logic              start_pop,
  input  logic [7:0]        a_in,
  input  logic              flag_z,
  input  logic              flag_n,
  input  logic              flag_h,
  input  logic              flag_c,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack,
  output logic [7:0]        a_out,
  output logic              a_load,
  output logic [3:0]        temp_flags,
  output logic              flags_load,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_load,
  output logic              busy
);
  import af_stack_port_pkg::*;

  localparam logic [ADDR_W-1:0] SpOne = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] SpTwo = ADDR_W'(2);

  state_e            state_q, state_d;
  gap_tag_e          tag_q, tag_d;
  logic              pop_q, pop_d;
  logic [7:0]        a_q, a_d;
  logic [3:0]        fl_q, fl_d;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [7:0]        a_out_q, a_out_d;
  logic [3:0]        tflags_q, tflags_d;
  logic [ADDR_W-1:0] sp_out_q, sp_out_d;

  logic [7:0] f_byte;
  logic [3:0] rd_flags;

  af_pack #(
    .F_LOW_MASK (F_LOW_MASK)
  ) u_pack (
    .z      (fl_q[3]),
    .n      (fl_q[2]),
    .h      (fl_q[1]),
    .c      (fl_q[0]),
    .rdata  (mem_rdata),
    .f_byte (f_byte),
    .flags  (rd_flags)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= StIdle;
      tag_q    <= GapToPushLo;
      pop_q    <= 1'b0;
      a_q      <= '0;
      fl_q     <= '0;
      sp_q     <= '0;
      a_out_q  <= '0;
      tflags_q <= '0;
      sp_out_q <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      pop_q    <= pop_d;
      a_q      <= a_d;
      fl_q     <= fl_d;
      sp_q     <= sp_d;
      a_out_q  <= a_out_d;
      tflags_q <= tflags_d;
      sp_out_q <= sp_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tag_d      = tag_q;
    pop_d      = pop_q;
    a_d        = a_q;
    fl_d       = fl_q;
    sp_d       = sp_q;
    a_out_d    = a_out_q;
    tflags_d   = tflags_q;
    sp_out_d   = sp_out_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    a_load     = 1'b0;
    flags_load = 1'b0;
    sp_load    = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Push has priority when both requests arrive together.
        if (start_push) begin
          a_d     = a_in;
          fl_d    = {flag_z, flag_n, flag_h, flag_c};
          sp_d    = sp_in;
          pop_d   = 1'b0;
          state_d = StPushHi;
        end else if (start_pop) begin
          sp_d    = sp_in;
          pop_d   = 1'b1;
          state_d = StPopLo;
        end
      end
      StPushHi: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q - SpOne;
        mem_wdata = a_q;
        if (mem_ack) begin
          tag_d   = GapToPushLo;
          state_d = StGap;
        end
      end
      StPushLo: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = sp_q - SpTwo;
        mem_wdata = f_byte;
        if (mem_ack) begin
          sp_out_d = sp_q - SpTwo;
          state_d  = StFinish;
        end
      end
      StPopLo: begin
        mem_req  = 1'b1;
        mem_addr = sp_q;
        if (mem_ack) begin
          tflags_d = rd_flags;
          tag_d    = GapToPopHi;
          state_d  = StGap;
        end
      end
      StPopHi: begin
        mem_req  = 1'b1;
        mem_addr = sp_q + SpOne;
        if (mem_ack) begin
          a_out_d  = mem_rdata;
          sp_out_d = sp_q + SpTwo;
          state_d  = StFinish;
        end
      end
      StGap: begin
        state_d = (tag_q == GapToPushLo) ? StPushLo : StPopHi;
      end
      StFinish: begin
        sp_load    = 1'b1;
        a_load     = pop_q;
        flags_load = pop_q;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign a_out      = a_out_q;
  assign temp_flags = tflags_q;
  assign sp_out     = sp_out_q;

endmodule
